// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory responder with wait states and fault reporting (optional DMEM_STATS_EN access counters)
module data_memory_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] alu_Out,
  input  logic [15:0] reg_Data_2,
  output logic [15:0] mem_Data_in,
  output logic        mem_ready,
  output logic        mem_fault,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  output logic        busy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_rd_q, op_rd_d;
  logic                op_wr_q, op_wr_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;

  logic [15:0]         data_q;
  logic                ready_q;
  logic                flt_q;

  logic [15:0]         ram_q [DEPTH];

  logic                accept;
  logic                range_bad;
  logic                complete;
  logic                commit_wr;
  logic                good_rd;

  // An access is taken only from IDLE, and only once per strobe assertion
  assign accept    = (state_q == ST_IDLE) && armed_q && (mem_rd || mem_wr);
  assign range_bad = |(alu_Out >> ADDR_W);
  assign complete  = (state_q == ST_DONE);
  assign commit_wr = complete && op_wr_q && !fault_q;
  assign good_rd   = complete && op_rd_q && !fault_q;

  // Next-state logic: capture the request, count wait states, finish in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_rd_d = mem_rd;
          op_wr_d = mem_wr;
          fault_d = (mem_rd && mem_wr) || range_bad;
          addr_d  = alu_Out[ADDR_W-1:0];
          wdata_d = reg_Data_2;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WS_LAST - 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Re-arm only once both strobes have been seen low, so a held strobe is a single access
  always_comb begin
    armed_d = armed_q;
    if (accept) begin
      armed_d = 1'b0;
    end else if (!mem_rd && !mem_wr) begin
      armed_d = 1'b1;
    end
  end

  // Control and request-capture registers; reset drops any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
      cnt_q   <= 4'd0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Completion outputs are registered on the edge leaving DONE, together with the RAM commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      flt_q   <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      ready_q <= complete;
      flt_q   <= complete && fault_q;
      if (complete && op_rd_q) begin
        data_q <= fault_q ? 16'h0000 : ram_q[addr_q];
      end
    end
  end

  // Word RAM; contents survive reset, writes land only for clean write accesses
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      ram_q[addr_q] <= wdata_q;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Saturating counters of clean reads and writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else begin
      if (good_rd && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (commit_wr && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  logic unused_good_rd;
  assign unused_good_rd = good_rd;
`endif

  assign mem_Data_in = data_q;
  assign mem_ready   = ready_q;
  assign mem_fault   = flt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder (WAIT_STATES=1 and =0 instances)
module tb_data_memory_responder;

  localparam int AW    = 6;
  localparam int WORDS = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        rd_s = '0;
  logic [1:0]        wr_s = '0;
  logic [1:0][15:0]  addr_s = '0;
  logic [1:0][15:0]  wd_s = '0;
  logic [1:0][15:0]  dout_s;
  logic [1:0]        rdy_s;
  logic [1:0]        flt_s;
  logic [1:0]        busy_s;
`ifdef DMEM_STATS_EN
  logic [1:0][15:0]  rdc_s;
  logic [1:0][15:0]  wrc_s;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_W(AW), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .mem_rd(rd_s[0]), .mem_wr(wr_s[0]),
    .alu_Out(addr_s[0]), .reg_Data_2(wd_s[0]), .mem_Data_in(dout_s[0]),
    .mem_ready(rdy_s[0]), .mem_fault(flt_s[0]),
`ifdef DMEM_STATS_EN
    .rd_count(rdc_s[0]), .wr_count(wrc_s[0]),
`endif
    .busy(busy_s[0])
  );

  data_memory_responder #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_rd(rd_s[1]), .mem_wr(wr_s[1]),
    .alu_Out(addr_s[1]), .reg_Data_2(wd_s[1]), .mem_Data_in(dout_s[1]),
    .mem_ready(rdy_s[1]), .mem_fault(flt_s[1]),
`ifdef DMEM_STATS_EN
    .rd_count(rdc_s[1]), .wr_count(wrc_s[1]),
`endif
    .busy(busy_s[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access accepted at edge e completes (ready, data, RAM update) at edge e+WS+1
  int unsigned e_cnt  [2] = '{0, 0};
  int unsigned acc_e  [2] = '{0, 0};
  bit          pend   [2] = '{0, 0};
  bit          armed  [2] = '{1, 1};
  bit          m_rd   [2];
  bit          m_flt  [2];
  int          m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_mem  [2][WORDS];
  bit          exp_rdy  [2] = '{0, 0};
  bit          exp_flt  [2] = '{0, 0};
  bit          exp_busy [2] = '{0, 0};
  logic [15:0] exp_data [2] = '{16'h0, 16'h0};
  bit          model_live = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k]     = 0;
        armed[k]    = 1;
        exp_rdy[k]  = 0;
        exp_flt[k]  = 0;
        exp_busy[k] = 0;
        exp_data[k] = 16'h0000;
      end else begin
        bit acc;
        e_cnt[k]++;
        acc = !pend[k] && armed[k] && (rd_s[k] || wr_s[k]);
        exp_rdy[k] = 0;
        exp_flt[k] = 0;
        if (pend[k] && (e_cnt[k] == acc_e[k] + ws_of(k) + 1)) begin
          exp_rdy[k] = 1;
          exp_flt[k] = m_flt[k];
          if (m_rd[k])
            exp_data[k] = m_flt[k] ? 16'h0000 : m_mem[k][m_addr[k]];
          else if (!m_flt[k])
            m_mem[k][m_addr[k]] = m_wd[k];
          pend[k] = 0;
        end
        if (acc) begin
          pend[k]   = 1;
          acc_e[k]  = e_cnt[k];
          m_rd[k]   = rd_s[k];
          m_flt[k]  = (rd_s[k] && wr_s[k]) || (addr_s[k] >= 16'(WORDS));
          m_addr[k] = int'(addr_s[k]) % WORDS;
          m_wd[k]   = wd_s[k];
          armed[k]  = 0;
        end else if (!rd_s[k] && !wr_s[k]) begin
          armed[k] = 1;
        end
        exp_busy[k] = pend[k];
      end
    end
    model_live = 1;
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("mem_ready[%0d]", k), rdy_s[k], exp_rdy[k]);
        chk($sformatf("mem_fault[%0d]", k), flt_s[k], exp_flt[k]);
        chk($sformatf("busy[%0d]", k), busy_s[k], exp_busy[k]);
        chk($sformatf("mem_Data_in[%0d]", k), dout_s[k], exp_data[k]);
      end
    end
  end

  // Drive one access, wait for mem_ready, report data/fault and edges from acceptance to ready
  task automatic access(input int k, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rdata, output bit flt,
                        output int lat);
    int n;
    @(negedge clk); #2;
    rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = addr; wd_s[k] = wd;
    n = 0; lat = -1; rdata = 16'h0; flt = 0;
    while (n < 40 && lat < 0) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (rdy_s[k]) begin
        lat   = n - 1;
        rdata = dout_s[k];
        flt   = flt_s[k];
      end
    end
    chk($sformatf("access_done[%0d]", k), (lat >= 0), 1);
    #2;
    rd_s[k] = 0; wr_s[k] = 0;
  endtask

  initial begin
    logic [15:0] d;
    bit          f;
    int          lat;
    int          pulses;

    repeat (2) @(negedge clk);
    chk("reset_ready", rdy_s, 2'b00);
    chk("reset_fault", flt_s, 2'b00);
    chk("reset_busy", busy_s, 2'b00);
    chk("reset_data", dout_s, 32'h0);
    #2 rst = 0;

    // Write then read at WAIT_STATES=1
    access(0, 0, 1, 16'd5, 16'h1234, d, f, lat);
    chk("wr5_latency", lat, 2);
    chk("wr5_fault", f, 0);
    access(0, 1, 0, 16'd5, 16'h0000, d, f, lat);
    chk("rd5_data", d, 16'h1234);
    chk("rd5_latency", lat, 2);

    // Reset in the middle of a pending write
    access(0, 0, 1, 16'd3, 16'h5A5A, d, f, lat);
    @(negedge clk); #2;
    wr_s[0] = 1; addr_s[0] = 16'd3; wd_s[0] = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_busy", busy_s[0], 1);
    #2 rst = 1; wr_s[0] = 0;
    @(negedge clk); #2 rst = 0;
    access(0, 1, 0, 16'd3, 16'h0000, d, f, lat);
    chk("rst_rd3_data", d, 16'h5A5A);
    chk("rst_rd3_fault", f, 0);

    // Held strobe gives one access; drop-and-reassert gives another
    access(0, 0, 1, 16'd7, 16'h0777, d, f, lat);
    @(negedge clk); #2;
    rd_s[0] = 1; addr_s[0] = 16'd7;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_s[0]) pulses++;
    end
    chk("held_pulses", pulses, 1);
    chk("held_data", dout_s[0], 16'h0777);
    #2 rd_s[0] = 0;
    @(negedge clk); #2 rd_s[0] = 1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy_s[0]) pulses++;
    end
    chk("rearm_pulses", pulses, 1);
    #2 rd_s[0] = 0;

    // Out-of-range write faults and leaves RAM alone
    access(0, 0, 1, 16'd0, 16'h0F0F, d, f, lat);
    access(0, 0, 1, 16'h0040, 16'hAAAA, d, f, lat);
    chk("oor_wr_fault", f, 1);
    access(0, 1, 0, 16'd0, 16'h0000, d, f, lat);
    chk("oor_rd0_data", d, 16'h0F0F);
    chk("oor_rd0_fault", f, 0);
    access(0, 1, 0, 16'h8001, 16'h0000, d, f, lat);
    chk("oor_rd_fault", f, 1);
    chk("oor_rd_data", d, 16'h0000);

    // Both strobes high faults with zero data and no write
    access(0, 0, 1, 16'd2, 16'h2222, d, f, lat);
    access(0, 1, 1, 16'd2, 16'h5555, d, f, lat);
    chk("both_fault", f, 1);
    chk("both_data", d, 16'h0000);
    access(0, 1, 0, 16'd2, 16'h0000, d, f, lat);
    chk("both_rd2_data", d, 16'h2222);

    // WAIT_STATES=0 sweep over the full address space
    for (int a = 0; a < WORDS; a++) begin
      access(1, 0, 1, 16'(a), 16'(a * 3), d, f, lat);
      chk($sformatf("sweep_wr_lat[%0d]", a), lat, 1);
    end
    for (int a = 0; a < WORDS; a++) begin
      access(1, 1, 0, 16'(a), 16'h0000, d, f, lat);
      chk($sformatf("sweep_rd_data[%0d]", a), d, 16'(a * 3));
      chk($sformatf("sweep_rd_lat[%0d]", a), lat, 1);
    end
`ifdef DMEM_STATS_EN
    chk("sweep_wr_count", wrc_s[1], 16'd64);
    chk("sweep_rd_count", rdc_s[1], 16'd64);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
